ssd_bank_ctrl: RTL and testbench
================================

# ssd_bank_ctrl

Parametrised next-generation SSD storage controller: a single-port word-addressed store behind a valid/ready request channel and a valid/ready response channel. It models fixed flash read and program latencies and flags out-of-range accesses. It replaces the fixed 1024x32, same-cycle-ready controller between the host interface and the storage array, and adds backpressure, a latency model and error reporting.

## Interface
- DATA_W, 32: data word width.
- DEPTH, 1024: number of words. Legal range 2..2^20.
- READ_LAT, 2: cycles from read accept to response. Must be >= 1.
- PROG_LAT, 4: cycles from write accept to response. Must be >= 1.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  DATA_W  read data. 0 for writes and for errors.
- rsp_err  out  1  address was >= DEPTH.
- busy  out  1  equals !req_ready.
- rd_count, wr_count, err_count  out  16 each  statistics counters. See Configuration.

## Operation
- States: IDLE, RD_WAIT, PG_WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch the address, data, op and range check, load the latency counter, and go to RD_WAIT or PG_WAIT.
- RD_WAIT/PG_WAIT: the counter decrements each cycle. When it reaches its final count, go to RESP.
  - A read samples the array at this point.
  - A write commits req_wdata to the array at this point.
- Out-of-range requests still take the full latency. They do not write the array. They return rsp_err=1 and rsp_rdata=0.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err stay stable until rsp_valid && rsp_ready. The controller returns to IDLE on that edge.
- Only one request is outstanding at a time. req_ready=0 in every state except IDLE.
- Reset puts the FSM in IDLE and clears req_ready=1 (IDLE value), rsp_valid=0, rsp_rdata=0, rsp_err=0 and the counters. Array contents are not cleared.
- Reset during RD_WAIT/PG_WAIT aborts the operation. An aborted write never reaches the array.

## Timing
- Request accepted at edge E0 (req_valid && req_ready).
- A read has rsp_valid=1 from after edge E0+READ_LAT. A write has rsp_valid=1 from after edge E0+PROG_LAT.
- If rsp_ready is held high, response accept occurs at the first RESP edge. req_ready is high in the following cycle.
- Peak throughput is one read per READ_LAT+2 cycles and one write per PROG_LAT+2 cycles.
- Read-after-write to the same address returns the new data, because the write commits before its response.
- Inputs are ignored outside IDLE, except rsp_ready in RESP.
- rsp_ready asserted outside RESP has no effect.

## Configuration
- SSD_STATS_EN defined:
  - rd_count, wr_count and err_count each increment on the response-accept edge of the matching operation.
  - An errored operation increments err_count only.
  - All three counters saturate at 0xFFFF and are cleared by reset.
- SSD_STATS_EN undefined: the three ports remain and are tied to 0, and no counter logic is built.

## Structure
- Package ssd_pkg holds:
  - the state enum (IDLE, RD_WAIT, PG_WAIT, RESP);
  - the op encoding (OP_RD=0, OP_WR=1);
  - the shared constant STAT_W=16.
- Sub-module ssd_mem_array: single-port synchronous RAM with parameters DATA_W and DEPTH, inputs we, addr, wdata, output rdata. It has no reset.

## Test plan
- Write, then read, at default parameters:
  - write 0xDEADBEEF to addr 5 -> rsp_valid rises 4 cycles after accept, rsp_err=0;
  - read addr 5 -> rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF.
- Out-of-range access: write to addr 1024, then read addr 1024 -> both responses have rsp_err=1 and rsp_rdata=0, and the contents of addr 0 are unchanged.
- Response backpressure: read with rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0 throughout. When rsp_ready rises, req_ready=1 one cycle later.
- Reset during a write: write 0x12345678 to addr 7, which already holds 0xA5A5A5A5, and assert reset 2 cycles after accept -> after reset, reading addr 7 returns 0xA5A5A5A5, and req_ready=1 in the first post-reset cycle.
- Back-to-back traffic: 100 random reads and writes with random rsp_ready -> every response matches the scoreboard. With SSD_STATS_EN, the counters equal the scoreboard totals.
- Non-default parameters DATA_W=64, DEPTH=16, READ_LAT=1, PROG_LAT=1: write to addr 15, then read addr 15 -> data matches, and each response arrives 1 cycle after accept. Addr 16 is reported as an error.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and helpers for the SSD bank controller.
package ssd_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    PG_WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ssd_mem_array.sv
// Single-port synchronous word RAM; registered read, no reset.
module ssd_mem_array
  import ssd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ssd_bank_ctrl.sv
// SSD bank controller with flash latency model and range checking.
// Optional statistics counters built when SSD_STATS_EN is defined.
module ssd_bank_ctrl
  import ssd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 2,
  parameter int PROG_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [STAT_W-1:0] rd_count,
  output logic [STAT_W-1:0] wr_count,
  output logic [STAT_W-1:0] err_count
);

  localparam int AW = addr_w(DEPTH);

  state_t            state, state_nx;
  logic [AW-1:0]     addr_q, mem_addr;
  logic [DATA_W-1:0] wdata_q, mem_rdata;
  logic              err_q;
  logic [31:0]       cnt;
  logic              accept, rsp_fire, done;
  logic              waiting, we;

  assign accept   = (state == IDLE) && req_valid;
  assign rsp_fire = (state == RESP) && rsp_ready;
  assign waiting  = (state == RD_WAIT) || (state == PG_WAIT);
  assign done     = (cnt == 32'd0);

  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state == RESP);

  // An aborting reset must not let the final program edge commit.
  assign we = (state == PG_WAIT) && done && !err_q && !reset;

  // Read the live address in IDLE so data is ready for READ_LAT=1.
  assign mem_addr = (state == IDLE) ? req_addr[AW-1:0] : addr_q;

  ssd_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (mem_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = req_write ? PG_WAIT : RD_WAIT;
      RD_WAIT: if (done) state_nx = RESP;
      PG_WAIT: if (done) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        err_q   <= !(req_addr < 32'(DEPTH));
        cnt     <= req_write ? 32'(PROG_LAT - 1)
                             : 32'(READ_LAT - 1);
      end else if (waiting && !done) begin
        cnt <= cnt - 32'd1;
      end
      if (waiting && done) begin
        rsp_err   <= err_q;
        rsp_rdata <= (state == RD_WAIT && !err_q) ? mem_rdata : '0;
      end
    end
  end

`ifdef SSD_STATS_EN
  op_t               op_q;
  logic [STAT_W-1:0] rd_q, wr_q, er_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_RD;
      rd_q <= '0;
      wr_q <= '0;
      er_q <= '0;
    end else begin
      if (accept) op_q <= req_write ? OP_WR : OP_RD;
      if (rsp_fire) begin
        if (rsp_err)           er_q <= sat_inc(er_q);
        else if (op_q == OP_WR) wr_q <= sat_inc(wr_q);
        else                   rd_q <= sat_inc(rd_q);
      end
    end
  end

  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign err_count = er_q;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
  assign rd_count  = '0;
  assign wr_count  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ssd_bank_ctrl.sv
// Randomized self-checking bench for ssd_bank_ctrl against a word-map model.
// Also exercises a small 64-bit, single-cycle-latency instance.
module tb_ssd_bank_ctrl;
  import ssd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [15:0] rd_count, wr_count, err_count;

  logic        s_reset = 1'b1;
  logic        s_req_valid = 1'b0, s_req_write = 1'b0;
  logic [31:0] s_req_addr = '0;
  logic [63:0] s_req_wdata = '0;
  logic        s_rsp_ready = 1'b1;
  logic        s_req_ready, s_rsp_valid, s_rsp_err, s_busy;
  logic [63:0] s_rsp_rdata;
  logic [15:0] s_rd_count, s_wr_count, s_err_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [int];
  int exp_rd = 0, exp_wr = 0, exp_err = 0;

  always #5 clk = ~clk;

  ssd_bank_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count),
    .err_count(err_count)
  );

  ssd_bank_ctrl #(
    .DATA_W(64), .DEPTH(16), .READ_LAT(1), .PROG_LAT(1)
  ) dut_s (
    .clk(clk), .reset(s_reset),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_write(s_req_write), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata), .rsp_valid(s_rsp_valid),
    .rsp_ready(s_rsp_ready), .rsp_rdata(s_rsp_rdata),
    .rsp_err(s_rsp_err), .busy(s_busy),
    .rd_count(s_rd_count), .wr_count(s_wr_count),
    .err_count(s_err_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the main DUT; hold = cycles of rsp_ready low in RESP.
  task automatic run(input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input int hold);
    int n;
    int lat;
    logic [31:0] rd;
    bit inr;
    inr = (a < 1024);
    lat = wr ? 4 : 2;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
    rsp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    req_write = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    n = 0;
    while (!rsp_valid && n < 50) begin
      rsp_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    rsp_ready = 0;
    chk(wr ? "wr_latency" : "rd_latency", n, lat);
    if (!rsp_valid) return;
    rd = rsp_rdata;
    chk("rsp_err", rsp_err, !inr);
    if (wr || !inr) chk("rdata_zero", rd, 0);
    else if (model.exists(int'(a))) chk("rdata", rd, model[int'(a)]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("ready_after_rsp", req_ready, 1);
    chk("valid_after_rsp", rsp_valid, 0);
    if (wr && inr) model[int'(a)] = d;
    if (!inr) exp_err++;
    else if (wr) exp_wr++;
    else exp_rd++;
  endtask

  task automatic s_run(input bit wr, input logic [31:0] a,
                       input logic [63:0] d, input logic [63:0] er,
                       input bit eerr);
    int n;
    @(negedge clk);
    s_req_valid = 1; s_req_write = wr;
    s_req_addr = a; s_req_wdata = d;
    @(posedge clk); #1;
    s_req_valid = 0;
    n = 0;
    while (!s_rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_latency", n, 1);
    chk("s_rdata", s_rsp_rdata, er);
    chk("s_err", s_rsp_err, eerr);
    @(posedge clk); #1;
    chk("s_ready_after", s_req_ready, 1);
  endtask

  task automatic check_stats(input string tag);
`ifdef SSD_STATS_EN
    chk({tag, "_rd"}, rd_count, exp_rd);
    chk({tag, "_wr"}, wr_count, exp_wr);
    chk({tag, "_err"}, err_count, exp_err);
`else
    chk({tag, "_rd"}, rd_count, 0);
    chk({tag, "_wr"}, wr_count, 0);
    chk({tag, "_err"}, err_count, 0);
`endif
  endtask

  initial begin
    int n;
    bit wr;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 reset = 0; s_reset = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    check_stats("rst");

    run(1, 5, 32'hDEADBEEF, 0);
    run(0, 5, 0, 0);
    run(1, 0, 32'h11111111, 0);
    run(1, 1024, 32'hCAFEF00D, 0);
    run(0, 1024, 0, 0);
    run(0, 0, 0, 0);
    check_stats("early");
    run(0, 5, 0, 10);

    // Abort a program by reset two cycles after accept.
    run(1, 7, 32'hA5A5A5A5, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1;
    req_addr = 7; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", rsp_valid, 0);
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    check_stats("post_rst");
    run(0, 7, 0, 0);
    chk("abort_model", model[7], 32'hA5A5A5A5);

    for (int i = 0; i < 100; i++) begin
      wr = 1'($urandom);
      n = int'($urandom_range(0, 17));
      a = (n == 17) ? 32'(1024 + $urandom_range(0, 5000)) : 32'(n);
      run(wr, a, $urandom, int'($urandom_range(0, 3)));
    end
    check_stats("final");

    s_run(1, 15, 64'h0123456789ABCDEF, 64'h0, 0);
    s_run(0, 15, 64'h0, 64'h0123456789ABCDEF, 0);
    s_run(0, 16, 64'h0, 64'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
